// File: rtl/sifh_window_scheduler_pkg.sv
// Shared defaults and FSM encoding for the SiFH fine-window scheduler slice.
package sifh_window_scheduler_pkg;

    localparam int NB_DEF       = 4;
    localparam int NP_DEF       = 10;
    localparam int PIX_NUM_DEF  = 4;
    localparam int HALF_WIN_DEF = 3 << (NP_DEF - NB_DEF - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_DRAIN   = 3'd2;
    localparam logic [2:0] ST_PUBLISH = 3'd3;
    localparam logic [2:0] ST_FINE    = 3'd4;

    typedef enum logic [2:0] {
        IDLE    = ST_IDLE,
        COLLECT = ST_COLLECT,
        DRAIN   = ST_DRAIN,
        PUBLISH = ST_PUBLISH,
        FINE    = ST_FINE
    } schedStateT;

endpackage

// File: rtl/sifh_window_scheduler_if.sv
// Peak-result handshake and published window set between peak finder, scheduler and fine pass.
interface sifh_window_scheduler_if
    import sifh_window_scheduler_pkg::*;
#(
    parameter int NB                = NB_DEF,
    parameter int NP                = NP_DEF,
    parameter int PIXEL_NUM_PER_RAM = PIX_NUM_DEF,
    parameter int PIX_W             = $clog2(PIXEL_NUM_PER_RAM)
);

    logic                            peakValid;
    logic                            peakReady;
    logic [PIX_W-1:0]                peakPix;
    logic [NB-1:0]                   peakCH;
    logic [PIXEL_NUM_PER_RAM*NP-1:0] thMinus;
    logic [PIXEL_NUM_PER_RAM*NP-1:0] thPositive;
    logic [PIXEL_NUM_PER_RAM*NP-1:0] delta;
    logic                            windowsValid;
    logic                            windowsAck;

    modport master (
        output peakValid, peakPix, peakCH, windowsAck,
        input  peakReady, thMinus, thPositive, delta, windowsValid
    );

    modport slave (
        input  peakValid, peakPix, peakCH, windowsAck,
        output peakReady, thMinus, thPositive, delta, windowsValid
    );

endinterface

// File: rtl/sifh_window_calc.sv
// Combinational coarse-peak -> clamped fine window (lo, hi, step) calculation.
module sifh_window_calc
    import sifh_window_scheduler_pkg::*;
#(
    parameter int NB       = NB_DEF,
    parameter int NP       = NP_DEF,
    parameter int HALF_WIN = 3 << (NP - NB - 1)
) (
    input  logic [NB-1:0] peakCH,
    output logic [NP-1:0] lo,
    output logic [NP-1:0] hi,
    output logic [NP-1:0] delta
);

    localparam logic [NP:0] HW   = (NP+1)'(HALF_WIN);
    localparam logic [NP:0] MAXV = {1'b0, {NP{1'b1}}};

    typedef struct packed {
        logic [NP-1:0] lo;
        logic [NP-1:0] hi;
        logic [NP-1:0] dlt;
    } winT;

    // One extra bit of headroom keeps ch+HW and the clamp compares from wrapping.
    function automatic winT clampWindow(input logic [NP:0] ch);
        winT         w;
        logic [NP:0] l;
        logic [NP:0] h;
        if (ch <= HW) begin
            l = '0;
            h = HW << 1;
        end else if (ch >= MAXV - HW) begin
            h = MAXV;
            l = MAXV - (HW << 1);
        end else begin
            l = ch - HW;
            h = ch + HW;
        end
        w.lo  = NP'(l);
        w.hi  = NP'(h);
        w.dlt = NP'((h - l) >> NB);
        return w;
    endfunction

    logic [NP:0] chFine;
    winT         win;

    assign chFine = {1'b0, peakCH, {(NP-NB){1'b0}}};
    assign win    = clampWindow(chFine);
    assign lo     = win.lo;
    assign hi     = win.hi;
    assign delta  = win.dlt;

endmodule

// File: rtl/sifh_window_scheduler.sv
// Frame controller: gathers coarse peaks, builds per-pixel fine windows, then gates the fine pass.
module sifh_window_scheduler
    import sifh_window_scheduler_pkg::*;
#(
    parameter int NB                = NB_DEF,
    parameter int NP                = NP_DEF,
    parameter int PIXEL_NUM_PER_RAM = PIX_NUM_DEF,
    parameter int PIX_W             = $clog2(PIXEL_NUM_PER_RAM),
    parameter int HALF_WIN          = 3 << (NP - NB - 1)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   frameStart,
    input  logic                   fineDone,
    output logic                   fineEnable,
    output logic                   frameDone,
    output logic                   busy,
    sifh_window_scheduler_if.slave bus
);

    localparam int PN = PIXEL_NUM_PER_RAM;

    function automatic logic pixInRange(input logic [PIX_W-1:0] p);
        return 32'(p) < PN;
    endfunction

    function automatic logic [PN-1:0] pixBit(input logic [PIX_W-1:0] p);
        return pixInRange(p) ? (PN'(1) << p) : '0;
    endfunction

    schedStateT       state;
    logic [PN-1:0]    doneMask;
    logic             peakReadyR;
    logic             windowsValidR;
    logic             fineEnableR;
    logic             frameDoneR;
    logic             busyR;

    logic             accept;
    logic [PN-1:0]    stageBit;
    logic [PN-1:0]    acceptBit;

    logic             vld_p0;
    logic [PIX_W-1:0] pix_p0;
    logic [NB-1:0]    ch_p0;

    logic [NP-1:0]    winLo;
    logic [NP-1:0]    winHi;
    logic [NP-1:0]    winDelta;

    logic [PN*NP-1:0] thMinusR;
    logic [PN*NP-1:0] thPositiveR;
    logic [PN*NP-1:0] deltaR;

    assign accept    = bus.peakValid & peakReadyR;
    assign stageBit  = vld_p0 ? pixBit(pix_p0) : '0;
    assign acceptBit = pixBit(bus.peakPix);

    // Stage p0: capture the accepted peak result.
    always_ff @(posedge clk) begin
        if (!rstn) vld_p0 <= 1'b0;
        else       vld_p0 <= accept;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pix_p0 <= bus.peakPix;
            ch_p0  <= bus.peakCH;
        end
    end

    sifh_window_calc #(
        .NB       (NB),
        .NP       (NP),
        .HALF_WIN (HALF_WIN)
    ) uCalc (
        .peakCH (ch_p0),
        .lo     (winLo),
        .hi     (winHi),
        .delta  (winDelta)
    );

    // Stage p1: commit the computed window into the pixel's slot.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            thMinusR    <= '0;
            thPositiveR <= '0;
            deltaR      <= '0;
        end else if (vld_p0 && pixInRange(pix_p0)) begin
            thMinusR[int'(pix_p0)*NP +: NP]    <= winLo;
            thPositiveR[int'(pix_p0)*NP +: NP] <= winHi;
            deltaR[int'(pix_p0)*NP +: NP]      <= winDelta;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state         <= IDLE;
            doneMask      <= '0;
            peakReadyR    <= 1'b0;
            windowsValidR <= 1'b0;
            fineEnableR   <= 1'b0;
            frameDoneR    <= 1'b0;
            busyR         <= 1'b0;
        end else begin
            frameDoneR <= 1'b0;
            case (state)
                IDLE: begin
                    if (frameStart) begin
                        state      <= COLLECT;
                        doneMask   <= '0;
                        peakReadyR <= 1'b1;
                        busyR      <= 1'b1;
                    end
                end
                COLLECT: begin
                    doneMask <= doneMask | stageBit;
                    // The accepted result still in flight counts toward completion.
                    if (accept && (&(doneMask | stageBit | acceptBit))) begin
                        state      <= DRAIN;
                        peakReadyR <= 1'b0;
                    end
                end
                DRAIN: begin
                    doneMask      <= doneMask | stageBit;
                    state         <= PUBLISH;
                    windowsValidR <= 1'b1;
                end
                PUBLISH: begin
                    if (bus.windowsAck) begin
                        state         <= FINE;
                        windowsValidR <= 1'b0;
                        fineEnableR   <= 1'b1;
                    end
                end
                FINE: begin
                    // frameDone is shown while still busy; IDLE follows one cycle later.
                    if (frameDoneR) begin
                        state <= IDLE;
                        busyR <= 1'b0;
                    end else if (fineDone) begin
                        frameDoneR  <= 1'b1;
                        fineEnableR <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    peakReadyR    <= 1'b0;
                    windowsValidR <= 1'b0;
                    fineEnableR   <= 1'b0;
                    busyR         <= 1'b0;
                end
            endcase
        end
    end

    assign bus.peakReady    = peakReadyR;
    assign bus.windowsValid = windowsValidR;
    assign bus.thMinus      = thMinusR;
    assign bus.thPositive   = thPositiveR;
    assign bus.delta        = deltaR;
    assign fineEnable       = fineEnableR;
    assign frameDone        = frameDoneR;
    assign busy             = busyR;

endmodule

// File: tb/tb_sifh_window_scheduler.sv
// Directed bench for sifh_window_scheduler; 3-bit pixel index so out-of-range pixels can be driven.
module tb_sifh_window_scheduler;

    localparam int NB = 4;
    localparam int NP = 10;
    localparam int PN = 4;
    localparam int PW = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic frameStart = 1'b0;
    logic fineDone = 1'b0;
    logic fineEnable;
    logic frameDone;
    logic busy;

    int total = 0;
    int bad = 0;

    sifh_window_scheduler_if #(.NB(NB), .NP(NP), .PIXEL_NUM_PER_RAM(PN), .PIX_W(PW)) bus ();

    sifh_window_scheduler #(.NB(NB), .NP(NP), .PIXEL_NUM_PER_RAM(PN), .PIX_W(PW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .frameStart (frameStart),
        .fineDone   (fineDone),
        .fineEnable (fineEnable),
        .frameDone  (frameDone),
        .busy       (busy),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic logic [NP-1:0] ent(input logic [PN*NP-1:0] v, input int i);
        return v[i*NP +: NP];
    endfunction

    task automatic chkWin(input string tag, input int i, input int lo, input int hi, input int d);
        chk({tag, "_lo"}, 64'(ent(bus.thMinus, i)), 64'(lo));
        chk({tag, "_hi"}, 64'(ent(bus.thPositive, i)), 64'(hi));
        chk({tag, "_dl"}, 64'(ent(bus.delta, i)), 64'(d));
    endtask

    task automatic sendPeak(input logic [PW-1:0] pix, input logic [NB-1:0] ch);
        bus.peakValid = 1'b1;
        bus.peakPix   = pix;
        bus.peakCH    = ch;
        tick();
        bus.peakValid = 1'b0;
    endtask

    task automatic startFrame();
        frameStart = 1'b1;
        tick();
        frameStart = 1'b0;
    endtask

    initial begin
        int onCount;
        logic [PN*NP-1:0] heldMinus;
        bus.peakValid  = 1'b0;
        bus.peakPix    = '0;
        bus.peakCH     = '0;
        bus.windowsAck = 1'b0;

        // reset state
        tick();
        tick();
        chk("rst_ready", bus.peakReady, 0);
        chk("rst_wvalid", bus.windowsValid, 0);
        chk("rst_fineen", fineEnable, 0);
        chk("rst_framedone", frameDone, 0);
        chk("rst_busy", busy, 0);
        chk("rst_thm", bus.thMinus, 0);
        chk("rst_thp", bus.thPositive, 0);
        chk("rst_delta", bus.delta, 0);
        rstn = 1'b1;
        tick();

        // normal frame, back-to-back accepts
        startFrame();
        chk("f1_busy", busy, 1);
        chk("f1_ready", bus.peakReady, 1);
        sendPeak(3'd0, 4'd5);
        sendPeak(3'd1, 4'd0);
        sendPeak(3'd2, 4'd15);
        sendPeak(3'd3, 4'd14);
        chk("f1_drain_ready", bus.peakReady, 0);
        chk("f1_drain_wvalid", bus.windowsValid, 0);
        tick();
        chk("f1_wvalid", bus.windowsValid, 1);
        chkWin("f1_p0", 0, 224, 416, 12);
        chkWin("f1_p1", 1, 0, 192, 12);
        chkWin("f1_p2", 2, 831, 1023, 12);
        chkWin("f1_p3", 3, 800, 992, 12);

        // windows held while ack is low
        heldMinus = bus.thMinus;
        onCount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.windowsValid === 1'b1) onCount++;
        end
        chk("f1_hold_cycles", onCount, 10);
        chk("f1_hold_thm", bus.thMinus, heldMinus);
        chk("f1_hold_fineen", fineEnable, 0);

        bus.windowsAck = 1'b1;
        tick();
        bus.windowsAck = 1'b0;
        chk("f1_ack_wvalid", bus.windowsValid, 0);
        onCount = (fineEnable === 1'b1) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            frameStart = (i == 0);
            tick();
            frameStart = 1'b0;
            if (fineEnable === 1'b1) onCount++;
        end
        chk("f1_fine_busy", busy, 1);
        fineDone = 1'b1;
        tick();
        fineDone = 1'b0;
        chk("f1_fine_cycles", onCount, 20);
        chk("f1_framedone", frameDone, 1);
        chk("f1_fineen_off", fineEnable, 0);
        chk("f1_busy_during_done", busy, 1);
        tick();
        chk("f1_framedone_pulse", frameDone, 0);
        chk("f1_busy_off", busy, 0);
        chkWin("f1_idle_keep", 2, 831, 1023, 12);

        // duplicate pixel, out-of-range pixel, spurious fineDone
        startFrame();
        fineDone = 1'b1;
        tick();
        fineDone = 1'b0;
        chk("f2_spur_busy", busy, 1);
        chk("f2_spur_ready", bus.peakReady, 1);
        chk("f2_spur_fineen", fineEnable, 0);
        sendPeak(3'd1, 4'd5);
        sendPeak(3'd1, 4'd7);
        sendPeak(3'd4, 4'd0);
        tick();
        tick();
        chkWin("f2_dup", 1, 352, 544, 12);
        chkWin("f2_oor_keep", 0, 224, 416, 12);
        chk("f2_nopub_wvalid", bus.windowsValid, 0);
        chk("f2_nopub_ready", bus.peakReady, 1);
        sendPeak(3'd0, 4'd1);
        sendPeak(3'd2, 4'd14);
        sendPeak(3'd3, 4'd15);
        tick();
        chk("f2_wvalid", bus.windowsValid, 1);
        chkWin("f2_p0_low", 0, 0, 192, 12);
        chkWin("f2_p2", 2, 800, 992, 12);
        chkWin("f2_p3_high", 3, 831, 1023, 12);
        bus.windowsAck = 1'b1;
        tick();
        bus.windowsAck = 1'b0;
        fineDone = 1'b1;
        tick();
        fineDone = 1'b0;
        tick();
        chk("f2_idle", busy, 0);

        // reset mid-collect after two accepts
        startFrame();
        sendPeak(3'd0, 4'd3);
        sendPeak(3'd1, 4'd3);
        tick();
        chkWin("f3_pre_rst", 1, 96, 288, 12);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("f3_rst_busy", busy, 0);
        chk("f3_rst_ready", bus.peakReady, 0);
        chk("f3_rst_thm", bus.thMinus, 0);
        chk("f3_rst_thp", bus.thPositive, 0);
        chk("f3_rst_delta", bus.delta, 0);
        bus.peakValid = 1'b1;
        bus.peakPix   = 3'd0;
        bus.peakCH    = 4'd5;
        tick();
        tick();
        tick();
        bus.peakValid = 1'b0;
        chk("f3_idle_ready", bus.peakReady, 0);
        chk("f3_idle_thm", bus.thMinus, 0);
        chk("f3_idle_busy", busy, 0);
        startFrame();
        sendPeak(3'd0, 4'd2);
        sendPeak(3'd1, 4'd3);
        sendPeak(3'd2, 4'd4);
        sendPeak(3'd3, 4'd5);
        tick();
        chk("f3_wvalid", bus.windowsValid, 1);
        chkWin("f3_p0", 0, 32, 224, 12);
        chkWin("f3_p2", 2, 160, 352, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sifh_window_scheduler.md
Name: sifh_window_scheduler

Overview:
Frame-level controller for the SiFH two-pass dToF histogram pipeline.
- Collects per-pixel coarse peak bins from the peak detector over a valid/ready handshake.
- Computes the clamped fine-pass window (thMinus/thPositive/delta) for each pixel.
- Once every pixel of the RAM group has reported, publishes the window set and enables the fine pass until the fine histogrammer reports completion.
- Sits between the peak finder and the fine-histogram address generator.

Parameters:
NB, 4, coarse bin index width (bits)
NP, 10, fine timestamp width (bits); NP > NB+1
PIXEL_NUM_PER_RAM, 4, pixels served per histogram RAM
PIX_W, $clog2(PIXEL_NUM_PER_RAM), pixel index width
HALF_WIN, 3<<(NP-NB-1), half window in fine LSBs (1.5 coarse bins; 96 at defaults)

Ports:
clk  in  1  clock, all logic posedge
rstn  in  1  synchronous active-low reset
frameStart  in  1  single-cycle pulse; starts a frame from IDLE
peakValid  in  1  peak detector has a result
peakReady  out  1  scheduler accepts a result this cycle
peakPix  in  PIX_W  pixel index of the result
peakCH  in  NB  coarse peak bin
thMinus  out  PIXEL_NUM_PER_RAM*NP  packed lower bounds; pixel i at [i*NP +: NP]
thPositive  out  PIXEL_NUM_PER_RAM*NP  packed upper bounds
delta  out  PIXEL_NUM_PER_RAM*NP  packed fine bin step
windowsValid  out  1  window set is complete and stable
windowsAck  in  1  consumer has latched the windows
fineEnable  out  1  fine-pass histogramming is allowed
fineDone  in  1  pulse from the fine histogrammer
frameDone  out  1  single-cycle end-of-frame pulse
busy  out  1  state != IDLE

Behaviour:
- Reset (rstn=0 at clk edge):
  - All outputs are 0, including every packed window entry.
  - doneMask = 0, FSM = IDLE, stage register invalid.
  - Reset mid-frame discards all progress.
- FSM states: IDLE, COLLECT, DRAIN, PUBLISH, FINE.
- IDLE:
  - frameStart -> COLLECT; doneMask cleared in the same cycle.
  - Window registers keep their old values until overwritten.
  - peakValid is ignored.
- COLLECT:
  - peakReady = 1.
  - Accept = peakValid & peakReady; this registers {peakPix, peakCH} into the stage register.
  - The next cycle writes the computed window into entry peakPix and sets doneMask[peakPix]. Latency from accept to output update is 2 cycles.
  - Back-to-back accepts are supported at one per cycle.
  - A repeat result for the same pixel overwrites the window; the pixel is still counted once.
  - peakPix >= PIXEL_NUM_PER_RAM is accepted and dropped (no write, no mask bit).
  - When the mask becomes all ones through an accept -> DRAIN.
- DRAIN:
  - peakReady = 0.
  - Lasts one cycle so the last write lands, then -> PUBLISH.
- PUBLISH:
  - windowsValid = 1; holds until windowsAck is sampled high.
  - On ack -> FINE.
- FINE:
  - fineEnable = 1; windowsValid = 0.
  - On fineDone: frameDone = 1 for one cycle, then -> IDLE.
- frameStart outside IDLE is ignored.
- fineDone outside FINE is ignored.
- windowsAck outside PUBLISH is ignored.
- Window arithmetic (NP-bit unsigned; MAXV = 2^NP-1; CH = peakCH << (NP-NB)):
  - If CH <= HALF_WIN: lo = 0, hi = 2*HALF_WIN.
  - Else if CH >= MAXV-HALF_WIN: hi = MAXV, lo = MAXV-2*HALF_WIN.
  - Else: lo = CH-HALF_WIN, hi = CH+HALF_WIN.
  - delta = (hi-lo) >> NB.
  - Intermediates are NP+1 bits wide so nothing wraps; results always fit in NP bits.

Decomposition:
- Shared package/header: NB, NP, PIXEL_NUM_PER_RAM, HALF_WIN defaults; FSM state encoding (3-bit localparams).
- Sub-module: sifh_window_calc, a purely combinational peakCH -> {lo, hi, delta} calculation that also serves as the reference model for verification.

Test Plan:
- Normal frame at defaults: frameStart, then pixels 0..3 with peakCH = 5, 0, 15, 14 -> windows (lo,hi,delta) = (224,416,12), (0,192,12), (831,1023,12), (800,992,12). windowsValid rises 2 cycles after the 4th accept.
- Low boundary: peakCH = 1 (CH = 64 <= 96) -> (0,192,12). High boundary: peakCH = 14 (896 < 927) is unclamped; peakCH = 15 is clamped to hi = 1023.
- Duplicate and out-of-range pixel: pix1 = 5, then pix1 = 7, then pix 4 -> entry 1 = (352,544,12). The mask is still missing pixels, so no PUBLISH until 0, 2 and 3 arrive.
- Handshake: hold windowsAck low for 10 cycles -> windowsValid stays high and outputs stable. Ack, then fineDone after 20 cycles -> fineEnable high for exactly those cycles, frameDone pulses once, busy falls the next cycle.
- Reset mid-COLLECT after 2 accepts: rstn low for one cycle -> all outputs 0, IDLE. peakValid is ignored until frameStart.
- Spurious inputs: frameStart during FINE, fineDone during COLLECT -> no state change.
